bmp_cmd_sched: RTL

- Command scheduler between the CPU memory-mapped bus and the 6-bit BMP/font placement engine.
- Latches X/Y shadow registers and queues each control write (0xC00A), with a snapshot of X/Y, in a FIFO.
- Issues one placement command at a time, only when the placer is idle; exposes a status/flush register at 0xC00B.
- Lets software fire draw commands back-to-back without polling the placer.

---
 rtl/bmp_cmd_sched.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/bmp_cmd_sched.sv
// Command scheduler: queues BMP/font placement writes with their X/Y snapshot and issues them one at a time.
// Optional vsync frame gating of issue is enabled by defining BMP_VSYNC_GATE_EN.
module bmp_cmd_sched #(
  parameter int DEPTH    = 8,
  parameter int START_TO = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        bmp_sel,
  input  logic        wr_en,
  input  logic [15:0] addr,
  input  logic [15:0] databus,
  output logic [15:0] rd_data,
  input  logic        placer_busy,
  input  logic        vga_vs,
  output logic        add_img,
  output logic        add_fnt,
  output logic        rem_img,
  output logic [4:0]  image_indx,
  output logic [5:0]  fnt_indx,
  output logic [9:0]  xloc,
  output logic [8:0]  yloc,
  output logic        fifo_full,
  output logic        fifo_empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int EW = 35;
  localparam int TW = $clog2(START_TO + 1) + 1;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    ISSUE      = 2'd1,
    WAIT_START = 2'd2,
    WAIT_DONE  = 2'd3
  } state_t;

  state_t          state_reg;
  logic [9:0]      xs_reg;
  logic [8:0]      ys_reg;
  logic [EW-1:0]   mem [DEPTH];
  logic [AW-1:0]   wr_ptr_reg;
  logic [AW-1:0]   rd_ptr_reg;
  logic [5:0]      count_reg;
  logic            ovf_reg;
  logic [TW-1:0]   to_cnt_reg;
  logic [EW-1:0]   head;
  logic            reg_wr;
  logic            push_req;
  logic            push_ok;
  logic            flush;
  logic            ovf_clr;
  logic            pop;
  logic            issue_ok;

  assign reg_wr   = bmp_sel & wr_en;
  assign push_req = reg_wr && (addr == 16'hC00A);
  assign flush    = reg_wr && (addr == 16'hC00B) && databus[0];
  assign ovf_clr  = reg_wr && (addr == 16'hC00B) && databus[1];

  assign fifo_full  = (count_reg == 6'(DEPTH));
  assign fifo_empty = (count_reg == 6'd0);

  assign head    = mem[rd_ptr_reg];
  assign pop     = (state_reg == IDLE) && !fifo_empty && !placer_busy && issue_ok;
  // A push into a full FIFO still fits when the head leaves in the same cycle.
  assign push_ok = push_req && (!fifo_full || pop);

  assign rd_data = (bmp_sel && addr == 16'hC00B)
                 ? {ovf_reg, 2'b00, state_reg, count_reg, 3'b000, fifo_full, fifo_empty}
                 : 16'h0000;

`ifdef BMP_VSYNC_GATE_EN
  logic [2:0] vs_sync_reg;
  logic       gate_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      vs_sync_reg <= 3'b111;
      gate_reg    <= 1'b0;
    end else begin
      vs_sync_reg <= {vs_sync_reg[1:0], vga_vs};
      if (fifo_empty)
        gate_reg <= 1'b0;
      else if (vs_sync_reg[2] && !vs_sync_reg[1])
        gate_reg <= 1'b1;
    end
  end

  assign issue_ok = gate_reg;
`else
  logic unused_vs;
  assign unused_vs = vga_vs;
  assign issue_ok  = 1'b1;
`endif

  logic unused_head;
  assign unused_head = ^head[14:6];

  always_ff @(posedge clk) begin
    if (rst) begin
      xs_reg <= '0;
      ys_reg <= '0;
    end else begin
      if (reg_wr && addr == 16'hC008) xs_reg <= databus[9:0];
      if (reg_wr && addr == 16'hC009) ys_reg <= databus[8:0];
    end
  end

  // Storage array kept free of reset so it can map onto RAM.
  always_ff @(posedge clk) begin
    if (push_ok && !flush)
      mem[wr_ptr_reg] <= {xs_reg, ys_reg, databus};
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (pop)     rd_ptr_reg <= rd_ptr_reg + AW'(1);
      count_reg <= count_reg + {5'b0, push_ok} - {5'b0, pop};
    end
  end

  always_ff @(posedge clk) begin
    if (rst)
      ovf_reg <= 1'b0;
    else if (ovf_clr)
      ovf_reg <= 1'b0;
    else if (push_req && fifo_full && !pop && !flush)
      ovf_reg <= 1'b1;
  end

  // Pulses are loaded at pop so they are high exactly during the ISSUE cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= IDLE;
      to_cnt_reg <= '0;
      add_img    <= 1'b0;
      add_fnt    <= 1'b0;
      rem_img    <= 1'b0;
      image_indx <= '0;
      fnt_indx   <= '0;
      xloc       <= '0;
      yloc       <= '0;
    end else begin
      add_img <= 1'b0;
      add_fnt <= 1'b0;
      rem_img <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (pop) begin
            xloc       <= head[34:25];
            yloc       <= head[24:16];
            image_indx <= head[5:1];
            fnt_indx   <= {1'b0, head[5:1]};
            add_img    <= head[0];
            add_fnt    <= ~head[0];
            rem_img    <= head[0] & head[15];
            state_reg  <= ISSUE;
          end
        end
        ISSUE: begin
          to_cnt_reg <= TW'(START_TO);
          state_reg  <= WAIT_START;
        end
        WAIT_START: begin
          if (placer_busy)
            state_reg <= WAIT_DONE;
          else if (to_cnt_reg <= TW'(1))
            state_reg <= IDLE;
          else
            to_cnt_reg <= to_cnt_reg - TW'(1);
        end
        WAIT_DONE: begin
          if (!placer_busy) state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule
